demux_stream: RTL

// - 1-to-2 stream demultiplexer: inverse of the 2:1 datapath mux; steers a 32-bit word to output 0 or 1 per select.
// - Each output channel has its own small FIFO with valid/ready handshake, so a stalled sink never corrupts the other path.
// - Sits between the write-back result path and two consumers (e.g. register-file write port and a debug/trace sink).

---
 rtl/demux_stream_pkg.sv | 15 +
 rtl/demux_stream_if.sv | 40 ++++
 rtl/demux_stream_chan_fifo.sv | 64 ++++++
 rtl/demux_stream.sv | 82 ++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared definitions for the 1:2 stream demultiplexer: word width and channel select codes.
// No logic here; constants only.
// Imported by the interface, the channel FIFO and the top.
package demux_stream_pkg;

    localparam int XLEN = 32;

    // in_select encodings
    localparam logic DEMUX_CH0 = 1'b0;
    localparam logic DEMUX_CH1 = 1'b1;

    // Default per-channel buffering
    localparam int DEMUX_DEPTH = 2;

endpackage

// File: rtl/demux_stream_if.sv
// Handshake bundle for demux_stream: one input stream, two output streams.
// master = producer/consumer side (drives inputs, ready), slave = demux side.
// Pure wiring, no state.
interface demux_stream_if
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = XLEN
);
    logic [DATA_W-1:0] in_data;
    logic              in_select;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_data_0;
    logic              out_valid_0;
    logic              out_ready_0;

    logic [DATA_W-1:0] out_data_1;
    logic              out_valid_1;
    logic              out_ready_1;

    modport master (
        output in_data, in_select, in_valid,
        input  in_ready,
        input  out_data_0, out_valid_0,
        output out_ready_0,
        input  out_data_1, out_valid_1,
        output out_ready_1
    );

    modport slave (
        input  in_data, in_select, in_valid,
        output in_ready,
        output out_data_0, out_valid_0,
        input  out_ready_0,
        output out_data_1, out_valid_1,
        input  out_ready_1
    );

endinterface

// File: rtl/demux_stream_chan_fifo.sv
// Per-channel FIFO (module demux_chan_fifo): DEPTH entries, strictly in-order.
// Latency: word pushed at edge N is on pop_data after edge N; no same-cycle bypass.
// Backpressure: push ignored when full, pop ignored when empty; full is not relieved by a same-cycle pop.
module demux_chan_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic push_ok;
    logic pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Empty channel presents zero rather than a stale entry.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: contents are only observable through a non-zero count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_stream.sv
// 1:2 stream demux steering each input word to channel 0/1 FIFO by in_select; optional DEMUX_COUNT_EN delivery counters.
// Latency: one cycle from accept to head of the selected channel.
// Backpressure: in_ready = not-full of the selected channel only; each sink stalls independently.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int DEPTH  = DEMUX_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    demux_stream_if.slave     bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [31:0]       cnt_0,
    output logic [31:0]       cnt_1
`endif
);
    logic full_0, full_1;
    logic empty_0, empty_1;
    logic push_0, push_1;
    logic pop_0, pop_1;

    // Ready depends only on the selected channel's fill level, never on in_valid.
    assign bus.in_ready = (bus.in_select == DEMUX_CH1) ? ~full_1 : ~full_0;

    // Gating by in_valid first keeps an unknown select from reaching either channel when idle.
    assign push_0 = bus.in_valid & (bus.in_select == DEMUX_CH0) & ~full_0;
    assign push_1 = bus.in_valid & (bus.in_select == DEMUX_CH1) & ~full_1;

    assign pop_0 = bus.out_ready_0 & ~empty_0;
    assign pop_1 = bus.out_ready_1 & ~empty_1;

    assign bus.out_valid_0 = ~empty_0;
    assign bus.out_valid_1 = ~empty_1;

    demux_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_chan_0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_0),
        .push_data (bus.in_data),
        .pop       (pop_0),
        .pop_data  (bus.out_data_0),
        .full      (full_0),
        .empty     (empty_0)
    );

    demux_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_chan_1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_1),
        .push_data (bus.in_data),
        .pop       (pop_1),
        .pop_data  (bus.out_data_1),
        .full      (full_1),
        .empty     (empty_1)
    );

`ifdef DEMUX_COUNT_EN
    // Delivered-word counters, free-running wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (pop_0) begin
                cnt_0 <= cnt_0 + 32'd1;
            end
            if (pop_1) begin
                cnt_1 <= cnt_1 + 32'd1;
            end
        end
    end
`endif

endmodule
